// File: rtl/inv_pkg.sv
// rtl/inv_pkg.sv - mode type and combinational operation shared by the inverter pipeline
package inv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INV    = 2'd1,
    MODE_MASK   = 2'd2,
    MODE_INVREV = 2'd3
  } mode_t;

  localparam int OP_MAX_W = 64;

  // Operates on a zero-extended operand; only the low 'width' bits are meaningful.
  function automatic logic [OP_MAX_W-1:0] inv_op(
    input logic [OP_MAX_W-1:0] a,
    input logic [OP_MAX_W-1:0] m,
    input mode_t               mode,
    input int                  width
  );
    logic [OP_MAX_W-1:0] y;
    y = a;
    case (mode)
      MODE_PASS: y = a;
      MODE_INV:  y = ~a;
      MODE_MASK: y = a ^ m;
      MODE_INVREV: begin
        y = '0;
        for (int i = 0; i < OP_MAX_W; i++) begin
          if (i < width) y[6'(i)] = ~a[6'(width - 1 - i)];
        end
      end
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/inv_stage.sv
// rtl/inv_stage.sv - one pipeline slot: valid bit plus data register with load enable
module inv_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data is only overwritten by a valid item so an emptied slot keeps its last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/inv_pipe.sv
// rtl/inv_pipe.sv - elastic DEPTH-stage pipeline applying pass/invert/mask/invert-reverse
module inv_pipe
  import inv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      xfer_cnt
);

  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_ld;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic [OP_MAX_W-1:0]         w_op_full;
  logic [WIDTH-1:0]            w_op;
  logic                        w_op_unused;
  logic [15:0]                 r_xfer_cnt;

  assign w_op_full   = inv_op(OP_MAX_W'(in_data), OP_MAX_W'(in_mask), mode_t'(in_mode), WIDTH);
  assign w_op        = w_op_full[WIDTH-1:0];
  assign w_op_unused = ^w_op_full;

  // A slot may load when it is empty or its successor is taking its item this cycle.
  always_comb begin
    logic [DEPTH-1:0] ld;
    ld = '0;
    ld[DEPTH-1] = !w_v[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      ld[k] = !w_v[k] || ld[k+1];
    end
    w_ld = ld;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_sv;
    logic [WIDTH-1:0] w_sd;
    if (k == 0) begin : g_head
      assign w_sv = in_valid;
      assign w_sd = w_op;
    end else begin : g_body
      assign w_sv = w_v[k-1];
      assign w_sd = w_d[k-1];
    end
    inv_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ld[k]),
      .i_valid (w_sv),
      .i_data  (w_sd),
      .o_valid (w_v[k]),
      .o_data  (w_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign in_ready  = w_ld[0] && !rst;
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_inv_pipe.sv
// tb/tb_inv_pipe.sv - directed table-driven bench for inv_pipe (8x2 and 1x1 instances)
module tb_inv_pipe;
  import inv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_in_mask, a_out_data;
  logic [1:0]  a_in_mode;
  logic [15:0] a_xfer_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0]  b_in_data, b_in_mask, b_out_data;
  logic [1:0]  b_in_mode;
  logic [15:0] b_xfer_cnt;

  inv_pipe #(.WIDTH(8), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_mask(a_in_mask),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .xfer_cnt(a_xfer_cnt)
  );

  inv_pipe #(.WIDTH(1), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_mask(b_in_mask),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .xfer_cnt(b_xfer_cnt)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];
  vec_t bv[4];

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst && a_out_valid && a_out_ready) got.push_back(a_out_data);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    mid();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{MODE_PASS,   8'hA5, 8'h00, 8'hA5};
    vt[1] = '{MODE_INV,    8'hA5, 8'h00, 8'h5A};
    vt[2] = '{MODE_MASK,   8'hA5, 8'h0F, 8'hAA};
    vt[3] = '{MODE_INVREV, 8'hA5, 8'h00, 8'h5A};
    vt[4] = '{MODE_INVREV, 8'h12, 8'h00, 8'hB7};
    vt[5] = '{MODE_MASK,   8'h3C, 8'hFF, 8'hC3};
    vt[6] = '{MODE_PASS,   8'h7E, 8'hFF, 8'h7E};
    vt[7] = '{MODE_INV,    8'h00, 8'h55, 8'hFF};
    vt[8] = '{MODE_INVREV, 8'h01, 8'h00, 8'h7F};
    vt[9] = '{MODE_INV,    8'hC0, 8'h00, 8'h3F};

    bv[0] = '{MODE_INV,    8'h01, 8'h00, 8'h00};
    bv[1] = '{MODE_PASS,   8'h00, 8'h01, 8'h00};
    bv[2] = '{MODE_INVREV, 8'h00, 8'h00, 8'h01};
    bv[3] = '{MODE_MASK,   8'h00, 8'h01, 8'h01};

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mask = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mask = '0; b_in_mode = '0; b_out_ready = 1'b1;
    cyc();
    cyc();
    mid();
    chk("rst_in_ready",  64'(a_in_ready),  64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_xfer_cnt",  64'(a_xfer_cnt),  64'd0);
    cyc();
    rst = 1'b0;
    mid();
    chk("post_rst_in_ready",   64'(a_in_ready), 64'd1);
    chk("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // Back-to-back stream: result of item t appears two cycles after it is presented.
    for (int t = 0; t < NV + 2; t++) begin
      cyc();
      if (t < NV) begin
        a_in_valid = 1'b1;
        a_in_mode  = vt[t].mode;
        a_in_data  = vt[t].data;
        a_in_mask  = vt[t].mask;
      end else begin
        a_in_valid = 1'b0;
      end
      mid();
      if (t < NV) chk($sformatf("tbl%0d_in_ready", t), 64'(a_in_ready), 64'd1);
      if (t >= 2) begin
        chk($sformatf("tbl%0d_out_valid", t - 2), 64'(a_out_valid), 64'd1);
        chk($sformatf("tbl%0d_out_data", t - 2), 64'(a_out_data), 64'(vt[t-2].exp));
      end else begin
        chk($sformatf("tbl_latency_c%0d", t), 64'(a_out_valid), 64'd0);
      end
    end
    cyc();
    mid();
    chk("tbl_drained", 64'(a_out_valid), 64'd0);
    chk("tbl_xfer_cnt", 64'(a_xfer_cnt), 64'd10);

    // Width 1, depth 1: result visible one cycle after presentation.
    for (int t = 0; t < 5; t++) begin
      cyc();
      if (t < 4) begin
        b_in_valid = 1'b1;
        b_in_mode  = bv[t].mode;
        b_in_data  = bv[t].data[0:0];
        b_in_mask  = bv[t].mask[0:0];
      end else begin
        b_in_valid = 1'b0;
      end
      mid();
      if (t < 4) chk($sformatf("w1_%0d_in_ready", t), 64'(b_in_ready), 64'd1);
      if (t >= 1) begin
        chk($sformatf("w1_%0d_out_valid", t - 1), 64'(b_out_valid), 64'd1);
        chk($sformatf("w1_%0d_out_data", t - 1), 64'(b_out_data), 64'(bv[t-1].exp[0:0]));
      end else begin
        chk("w1_latency", 64'(b_out_valid), 64'd0);
      end
    end
    cyc();
    mid();
    chk("w1_drained", 64'(b_out_valid), 64'd0);
    chk("w1_xfer_cnt", 64'(b_xfer_cnt), 64'd4);

    // Backpressure: two accepted, third stalls, then all three drain in order.
    do_reset();
    got.delete();
    mon_en = 1'b1;
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = MODE_PASS; a_in_data = 8'h11;
    mid(); chk("bp_acc0", 64'(a_in_ready), 64'd1);
    cyc(); a_in_data = 8'h22;
    mid(); chk("bp_acc1", 64'(a_in_ready), 64'd1);
    cyc(); a_in_data = 8'h33;
    mid(); chk("bp_full", 64'(a_in_ready), 64'd0);
    chk("bp_head", 64'(a_out_data), 64'h11);
    cyc();
    mid(); chk("bp_hold", 64'(a_in_ready), 64'd0);
    chk("bp_stable", 64'(a_out_data), 64'h11);
    chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
    cyc(); a_out_ready = 1'b1;
    mid(); chk("bp_pass", 64'(a_in_ready), 64'd1);
    cyc(); a_in_valid = 1'b0;
    repeat (6) cyc();
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_order%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(8'h11 * (i + 1)));
    end
    chk("bp_xfer_cnt", 64'(a_xfer_cnt), 64'd3);
    mon_en = 1'b0;

    // Full pipe streaming: ten cycles of simultaneous in/out transfers.
    do_reset();
    got.delete();
    mon_en = 1'b1;
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = MODE_PASS; a_in_data = 8'h40;
    cyc(); a_in_data = 8'h41;
    cyc(); a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 8'(8'h42 + i);
      mid();
      chk($sformatf("tp%0d_in_ready", i), 64'(a_in_ready), 64'd1);
      cyc();
    end
    a_in_valid = 1'b0;
    chk("tp_ten_xfers", 64'(got.size()), 64'd10);
    repeat (4) cyc();
    chk("tp_total", 64'(got.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tp_order%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(8'h40 + i));
    end
    chk("tp_xfer_cnt", 64'(a_xfer_cnt), 64'd12);
    mon_en = 1'b0;

    // Reset with the pipe full: nothing in flight may emerge or be counted.
    do_reset();
    got.delete();
    mon_en = 1'b1;
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = MODE_INV; a_in_data = 8'h77;
    cyc(); a_in_data = 8'h78;
    cyc(); a_in_valid = 1'b0;
    mid(); chk("rf_full", 64'(a_out_valid), 64'd1);
    cyc(); rst = 1'b1; a_out_ready = 1'b1;
    mid(); chk("rf_rst_in_ready", 64'(a_in_ready), 64'd0);
    cyc(); rst = 1'b0;
    mid();
    chk("rf_out_valid", 64'(a_out_valid), 64'd0);
    chk("rf_xfer_cnt",  64'(a_xfer_cnt),  64'd0);
    chk("rf_in_ready",  64'(a_in_ready),  64'd1);
    chk("rf_out_data",  64'(a_out_data),  64'd0);
    repeat (5) cyc();
    chk("rf_no_stale", 64'(got.size()), 64'd0);
    chk("rf_xfer_after", 64'(a_xfer_cnt), 64'd0);
    mon_en = 1'b0;

    // Counter wrap after 65536 transfers.
    do_reset();
    cyc(); a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_mode = MODE_INV; a_in_data = 8'h00;
    begin
      int n;
      n = 0;
      while (a_xfer_cnt != 16'hFFFF && n < 70000) begin
        cyc();
        n++;
      end
    end
    chk("wrap_reach", 64'(a_xfer_cnt), 64'hFFFF);
    chk("wrap_pending", 64'(a_out_valid), 64'd1);
    cyc();
    a_in_valid = 1'b0;
    chk("wrap_zero", 64'(a_xfer_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
